// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: a match launches a train of up to pMAX_PULSES pulses
// with per-pulse delay/gap and width, plus arming, abort and missed-match reporting.
module pw_trigger_seq #(
    parameter int unsigned pMAX_PULSES          = 4,
    parameter int unsigned pTRIGGER_DELAY_WIDTH = 20,
    parameter int unsigned pTRIGGER_WIDTH_WIDTH = 17,
    parameter int unsigned pIDX_WIDTH           = 4
) (
    input  logic                                        trigger_clk,
    input  logic                                        reset_n,
    input  logic                                        I_match,
    input  logic                                        I_arm,
    input  logic                                        I_oneshot,
    input  logic                                        I_abort,
    input  logic [pIDX_WIDTH-1:0]                       I_num_pulses,
    input  logic [pMAX_PULSES*pTRIGGER_DELAY_WIDTH-1:0] I_trigger_delay,
    input  logic [pMAX_PULSES*pTRIGGER_WIDTH_WIDTH-1:0] I_trigger_width,
    output logic                                        O_trigger,
    output logic                                        O_armed,
    output logic                                        O_busy,
    output logic [pIDX_WIDTH-1:0]                       O_pulse_idx,
    output logic                                        O_done,
    output logic                                        O_missed
);

    localparam int unsigned DW   = pTRIGGER_DELAY_WIDTH;
    localparam int unsigned WW   = pTRIGGER_WIDTH_WIDTH;
    localparam int unsigned IW   = pIDX_WIDTH;
    localparam int unsigned SelW = (pMAX_PULSES > 1) ? $clog2(pMAX_PULSES) : 1;

    typedef enum logic [1:0] {StIdle, StDelay, StPulse, StGap} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   num_q, num_d;
    logic [DW-1:0]   delay_q [pMAX_PULSES];
    logic [DW-1:0]   delay_d [pMAX_PULSES];
    logic [WW-1:0]   width_q [pMAX_PULSES];
    logic [WW-1:0]   width_d [pMAX_PULSES];
    logic            trig_q, trig_d;
    logic            armed_q, armed_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            missed_q, missed_d;

    logic [IW-1:0]   num_clamped;
    logic [IW-1:0]   idx_nxt;
    logic [SelW-1:0] sel_cur;
    logic [SelW-1:0] sel_nxt;
    logic            last_pulse;

    // Width fields of zero still give a one-cycle pulse.
    function automatic logic [WW-1:0] width_load(input logic [WW-1:0] w);
        return (w == '0) ? '0 : w - WW'(1);
    endfunction

    always_comb begin
        if (I_num_pulses == '0) begin
            num_clamped = IW'(1);
        end else if (I_num_pulses > IW'(pMAX_PULSES)) begin
            num_clamped = IW'(pMAX_PULSES);
        end else begin
            num_clamped = I_num_pulses;
        end
    end

    assign idx_nxt    = idx_q + IW'(1);
    assign sel_cur    = idx_q[SelW-1:0];
    assign sel_nxt    = idx_nxt[SelW-1:0];
    assign last_pulse = (idx_q == num_q - IW'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        idx_d    = idx_q;
        num_d    = num_q;
        delay_d  = delay_q;
        width_d  = width_q;
        trig_d   = trig_q;
        armed_d  = armed_q;
        done_d   = 1'b0;
        missed_d = 1'b0;

        if (I_abort) begin
            if (state_q != StIdle) begin
                state_d = StIdle;
                trig_d  = 1'b0;
                idx_d   = '0;
                armed_d = ~I_oneshot;
            end
        end else begin
            missed_d = I_match && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (I_arm && !armed_q) begin
                        armed_d = 1'b1;
                    end else if (I_match && armed_q) begin
                        num_d = num_clamped;
                        for (int i = 0; i < pMAX_PULSES; i++) begin
                            delay_d[i] = I_trigger_delay[i*DW +: DW];
                            width_d[i] = I_trigger_width[i*WW +: WW];
                        end
                        cnt_d   = I_trigger_delay[DW-1:0];
                        idx_d   = '0;
                        state_d = StDelay;
                    end
                end
                StDelay, StGap: begin
                    if (cnt_q == '0) begin
                        state_d = StPulse;
                        trig_d  = 1'b1;
                        wcnt_d  = width_load(width_q[sel_cur]);
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end
                StPulse: begin
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - WW'(1);
                    end else if (last_pulse) begin
                        trig_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                        idx_d   = '0;
                        armed_d = ~I_oneshot;
                    end else begin
                        idx_d = idx_nxt;
                        // A zero gap merges the next pulse onto this one.
                        if (delay_q[sel_nxt] == '0) begin
                            wcnt_d = width_load(width_q[sel_nxt]);
                        end else begin
                            trig_d  = 1'b0;
                            cnt_d   = delay_q[sel_nxt] - DW'(1);
                            state_d = StGap;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            idx_q    <= '0;
            num_q    <= '0;
            trig_q   <= 1'b0;
            armed_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
            for (int i = 0; i < pMAX_PULSES; i++) begin
                delay_q[i] <= '0;
                width_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            trig_q   <= trig_d;
            armed_q  <= armed_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            missed_q <= missed_d;
            for (int i = 0; i < pMAX_PULSES; i++) begin
                delay_q[i] <= delay_d[i];
                width_q[i] <= width_d[i];
            end
        end
    end

    assign O_trigger   = trig_q;
    assign O_armed     = armed_q;
    assign O_busy      = busy_q;
    assign O_pulse_idx = idx_q;
    assign O_done      = done_q;
    assign O_missed    = missed_q;

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Bench for pw_trigger_seq: an interval-level model predicts pulse trains, busy windows,
// done and missed events into queues; a negedge monitor pops and compares them.
module tb_pw_trigger_seq;

    localparam int NP = 4;
    localparam int DW = 20;
    localparam int WW = 17;
    localparam int IW = 4;

    logic               trigger_clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               I_match, I_arm, I_oneshot, I_abort;
    logic [IW-1:0]      I_num_pulses;
    logic [NP*DW-1:0]   I_trigger_delay;
    logic [NP*WW-1:0]   I_trigger_width;
    logic               O_trigger, O_armed, O_busy, O_done, O_missed;
    logic [IW-1:0]      O_pulse_idx;

    pw_trigger_seq #(
        .pMAX_PULSES         (NP),
        .pTRIGGER_DELAY_WIDTH(DW),
        .pTRIGGER_WIDTH_WIDTH(WW),
        .pIDX_WIDTH          (IW)
    ) dut (
        .trigger_clk    (trigger_clk),
        .reset_n        (reset_n),
        .I_match        (I_match),
        .I_arm          (I_arm),
        .I_oneshot      (I_oneshot),
        .I_abort        (I_abort),
        .I_num_pulses   (I_num_pulses),
        .I_trigger_delay(I_trigger_delay),
        .I_trigger_width(I_trigger_width),
        .O_trigger      (O_trigger),
        .O_armed        (O_armed),
        .O_busy         (O_busy),
        .O_pulse_idx    (O_pulse_idx),
        .O_done         (O_done),
        .O_missed       (O_missed)
    );

    always #5 trigger_clk = ~trigger_clk;

    typedef struct { int rise; int fall; } ival_t;

    ival_t exp_trig[$];
    ival_t exp_busy[$];
    int    exp_done[$];
    int    exp_missed[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge trigger_clk) cyc <= cyc + 1;

    // Stimulus for the next edge and the model state after the last edge.
    bit m_match, m_arm, m_oneshot;
    int m_num;
    int m_d[NP];
    int m_w[NP];
    int abort_off = -1;
    bit armed_m = 1'b1;
    bit seq_active = 1'b0;
    int seq_e0, seq_stop, seq_abort;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict the whole train of one sequence from its delay/gap/width arithmetic.
    task automatic start_seq(input int e0);
        int n, t, cr, full_end, ea;
        ival_t iv;
        ival_t seq[$];
        n = (m_num == 0) ? 1 : ((m_num > NP) ? NP : m_num);
        t = e0 + m_d[0] + 1;
        cr = t;
        for (int i = 0; i < n; i++) begin
            t += (m_w[i] == 0) ? 1 : m_w[i];
            if (i == n - 1) begin
                iv.rise = cr; iv.fall = t; seq.push_back(iv);
            end else if (m_d[i+1] != 0) begin
                iv.rise = cr; iv.fall = t; seq.push_back(iv);
                t += m_d[i+1];
                cr = t;
            end
        end
        full_end = t;
        ea = -1;
        if (abort_off >= 0) begin
            ea = e0 + abort_off;
            if (ea > full_end) ea = full_end;
            if (ea < e0 + 1) ea = e0 + 1;
        end
        foreach (seq[i]) begin
            iv = seq[i];
            if (ea < 0) begin
                exp_trig.push_back(iv);
            end else if (iv.rise < ea) begin
                if (iv.fall > ea) iv.fall = ea;
                exp_trig.push_back(iv);
            end
        end
        iv.rise = e0;
        iv.fall = (ea < 0) ? full_end : ea;
        exp_busy.push_back(iv);
        if (ea < 0) exp_done.push_back(full_end);
        seq_active = 1'b1;
        seq_e0 = e0;
        seq_stop = iv.fall;
        seq_abort = ea;
        abort_off = -1;
    endtask

    // Apply one edge of stimulus (called at a negedge, returns at the next negedge).
    task automatic step();
        int k;
        bit ab;
        k = cyc + 1;
        ab = 1'b0;
        if (seq_active && k > seq_e0) begin
            if (k == seq_abort) ab = 1'b1;
            else if (m_match) exp_missed.push_back(k);
            if (k == seq_stop) begin
                seq_active = 1'b0;
                armed_m = !m_oneshot;
            end
        end else begin
            if (m_arm && !armed_m) armed_m = 1'b1;
            else if (m_match && armed_m) start_seq(k);
        end
        I_match = m_match;
        I_arm = m_arm;
        I_oneshot = m_oneshot;
        I_abort = ab;
        I_num_pulses = IW'(m_num);
        for (int i = 0; i < NP; i++) begin
            I_trigger_delay[i*DW +: DW] = DW'(m_d[i]);
            I_trigger_width[i*WW +: WW] = WW'(m_w[i]);
        end
        @(posedge trigger_clk);
        @(negedge trigger_clk);
        check("armed", int'(O_armed), int'(armed_m));
        if (!seq_active) check("idx_idle", int'(O_pulse_idx), 0);
        m_match = 1'b0;
        m_arm = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle();
        int b = 0;
        while (seq_active && b < 3000) begin
            step();
            b++;
        end
        check("idle_reached", int'(seq_active), 0);
    endtask

    task automatic rand_cfg();
        m_num = $urandom_range(0, 15);
        for (int i = 0; i < NP; i++) begin
            m_d[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
            m_w[i] = $urandom_range(0, 5);
        end
    endtask

    task automatic set_cfg(input int n, input int d0, input int d1, input int d2, input int d3,
                           input int w0, input int w1, input int w2, input int w3);
        m_num = n;
        m_d[0] = d0; m_d[1] = d1; m_d[2] = d2; m_d[3] = d3;
        m_w[0] = w0; m_w[1] = w1; m_w[2] = w2; m_w[3] = w3;
    endtask

    // Monitor: turns output edges and pulses into events and checks them against the queues.
    bit    mon_en = 1'b0;
    logic  trig_p = 1'b0;
    logic  busy_p = 1'b0;
    int    trig_rise, busy_rise;
    ival_t mv;
    int    me;

    always @(negedge trigger_clk) begin
        if (mon_en) begin
            if (O_trigger && !trig_p) trig_rise = cyc;
            if (!O_trigger && trig_p) begin
                if (exp_trig.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL trig_unexpected: pulse %0d..%0d, expected none", trig_rise, cyc);
                end else begin
                    mv = exp_trig.pop_front();
                    check("trig_rise", trig_rise, mv.rise);
                    check("trig_fall", cyc, mv.fall);
                end
            end
            if (O_busy && !busy_p) busy_rise = cyc;
            if (!O_busy && busy_p) begin
                if (exp_busy.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL busy_unexpected: busy %0d..%0d, expected none", busy_rise, cyc);
                end else begin
                    mv = exp_busy.pop_front();
                    check("busy_rise", busy_rise, mv.rise);
                    check("busy_fall", cyc, mv.fall);
                end
            end
            if (O_done) begin
                if (exp_done.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected: done at %0d, expected none", cyc);
                end else begin
                    me = exp_done.pop_front();
                    check("done_edge", cyc, me);
                end
            end
            if (O_missed) begin
                if (exp_missed.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL missed_unexpected: missed at %0d, expected none", cyc);
                end else begin
                    me = exp_missed.pop_front();
                    check("missed_edge", cyc, me);
                end
            end
            trig_p = O_trigger;
            busy_p = O_busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int last_idx, b;
        int seen[$];
        int exp_idx[3];

        m_match = 0; m_arm = 0; m_oneshot = 0;
        set_cfg(1, 0, 0, 0, 0, 1, 1, 1, 1);
        I_match = 0; I_arm = 0; I_oneshot = 0; I_abort = 0;
        I_num_pulses = '0; I_trigger_delay = '0; I_trigger_width = '0;
        repeat (3) @(negedge trigger_clk);
        check("rst_trigger", int'(O_trigger), 0);
        check("rst_armed", int'(O_armed), 1);
        check("rst_busy", int'(O_busy), 0);
        check("rst_idx", int'(O_pulse_idx), 0);
        check("rst_done", int'(O_done), 0);
        check("rst_missed", int'(O_missed), 0);
        reset_n = 1'b1;
        mon_en = 1'b1;

        // Single 1-cycle pulse with zero delay.
        idle_steps(5);
        set_cfg(1, 0, 0, 0, 0, 1, 0, 0, 0);
        m_match = 1; step();
        wait_idle();

        // Three pulses, last merged, with pulse index tracking.
        set_cfg(3, 5, 2, 0, 0, 3, 4, 2, 0);
        m_match = 1; step();
        last_idx = 0;
        b = 0;
        while (seq_active && b < 200) begin
            step();
            b++;
            if (int'(O_pulse_idx) != last_idx) begin
                last_idx = int'(O_pulse_idx);
                seen.push_back(last_idx);
            end
        end
        exp_idx[0] = 1; exp_idx[1] = 2; exp_idx[2] = 0;
        check("idx_steps", seen.size(), 3);
        for (int i = 0; i < 3; i++)
            check("idx_value", (i < seen.size()) ? seen[i] : -1, exp_idx[i]);

        // One-shot: second match ignored, arm then match runs.
        m_oneshot = 1;
        set_cfg(1, 2, 0, 0, 0, 2, 0, 0, 0);
        m_match = 1; step();
        wait_idle();
        idle_steps(50);
        m_match = 1; step();
        idle_steps(10);
        m_arm = 1; step();
        m_match = 1; step();
        wait_idle();
        m_oneshot = 0;
        m_arm = 1; step();

        // Match during a pulse and config churn mid-run.
        set_cfg(2, 1, 3, 0, 0, 4, 2, 0, 0);
        m_match = 1; step();
        idle_steps(3);
        m_match = 1; step();
        while (seq_active) begin
            rand_cfg();
            step();
        end

        // Abort during the gap, then during a pulse.
        set_cfg(2, 2, 5, 0, 0, 2, 2, 0, 0);
        abort_off = 7;
        m_match = 1; step();
        wait_idle();
        abort_off = 4;
        m_match = 1; step();
        wait_idle();

        // Zero count and zero width, then count clamping.
        set_cfg(0, 1, 0, 0, 0, 0, 0, 0, 0);
        m_match = 1; step();
        wait_idle();
        set_cfg(15, 1, 1, 1, 1, 1, 1, 1, 1);
        m_match = 1; step();
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_cfg();
            m_match = ($urandom_range(0, 5) == 0);
            m_arm = ($urandom_range(0, 15) == 0);
            m_oneshot = ($urandom_range(0, 4) == 0);
            if (!seq_active)
                abort_off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            step();
        end
        m_oneshot = 0;
        abort_off = -1;
        wait_idle();
        idle_steps(3);
        check("q_trig_empty", exp_trig.size(), 0);
        check("q_busy_empty", exp_busy.size(), 0);
        check("q_done_empty", exp_done.size(), 0);
        check("q_missed_empty", exp_missed.size(), 0);

        // Asynchronous reset in the middle of a pulse.
        if (!armed_m) begin
            m_arm = 1; step();
        end
        set_cfg(1, 3, 0, 0, 0, 10, 0, 0, 0);
        m_match = 1; step();
        b = 0;
        while (!O_trigger && b < 50) begin
            step();
            b++;
        end
        check("rstmid_pulse_seen", int'(O_trigger), 1);
        mon_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_trigger", int'(O_trigger), 0);
        check("rstmid_armed", int'(O_armed), 1);
        check("rstmid_busy", int'(O_busy), 0);
        @(negedge trigger_clk);
        check("rstmid_done", int'(O_done), 0);
        reset_n = 1'b1;
        exp_trig.delete();
        exp_busy.delete();
        exp_done.delete();
        exp_missed.delete();
        seq_active = 1'b0;
        armed_m = 1'b1;
        idle_steps(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
